// File: rtl/xor_bist_ctrl_if.sv
// xor_bist_ctrl_if: test-controller and XOR-datapath signals of the BIST sequencer.
// master is the sequencer side; slave is the test controller plus datapath side.
interface xor_bist_ctrl_if #(parameter int WIDTH = 1);
    logic               start;
    logic [WIDTH-1:0]   dut_a;
    logic [WIDTH-1:0]   dut_b;
    logic [WIDTH-1:0]   dut_c;
    logic               busy;
    logic               done;
    logic               pass;
    logic [2*WIDTH:0]   err_cnt;
    logic [2*WIDTH-1:0] fail_vec;
    modport master (input start, dut_c, output dut_a, dut_b, busy, done, pass, err_cnt, fail_vec);
    modport slave  (output start, dut_c, input dut_a, dut_b, busy, done, pass, err_cnt, fail_vec);
endinterface

// File: rtl/xor_bist_ctrl.sv
// xor_bist_ctrl: exhaustive BIST sequencer for an XOR datapath with per-vector dwell.
// Define XOR_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module xor_bist_ctrl #(
    parameter int WIDTH = 1,
    parameter int DWELL = 10
) (
    input logic             clk,
    input logic             rst_n,
    xor_bist_ctrl_if.master bus
);
    localparam int VW = 2 * WIDTH;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [VW-1:0] vec_q, vec_d, ab_q, ab_d, fail_q, fail_d;
    logic [7:0]    dw_q, dw_d;
    logic [VW:0]   err_q, err_d;
    logic          pass_q, pass_d, mis, stop;
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        dw_d    = dw_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        mis     = bus.dut_c != (ab_q[VW-1:WIDTH] ^ ab_q[WIDTH-1:0]);
`ifdef XOR_BIST_STOP_ON_FAIL_EN
        stop    = mis | (&vec_q);
`else
        stop    = &vec_q;
`endif
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                vec_d   = '0;
                dw_d    = '0;
                err_d   = '0;
                fail_d  = '0;
                pass_d  = 1'b0;
            end
            RUN: if (dw_q != 8'(DWELL - 1)) dw_d = dw_q + 8'd1;
            else begin
                if (mis) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) fail_d = vec_q;
                end
                // pass must already be valid in the DONE cycle, so it is resolved on entry
                if (stop) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d = vec_q + 1'b1;
                    dw_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        ab_d = (state_d == RUN) ? vec_d : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            dw_q    <= '0;
            ab_q    <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dw_q    <= dw_d;
            ab_q    <= ab_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end
    assign bus.dut_a    = ab_q[VW-1:WIDTH];
    assign bus.dut_b    = ab_q[WIDTH-1:0];
    assign bus.busy     = state_q == RUN;
    assign bus.done     = state_q == DONE;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_vec = fail_q;
endmodule

// File: doc/xor_bist_ctrl.md
# xor_bist_ctrl

Built-in self-test sequencer for the XOR datapath. On a start pulse it drives every input combination onto the XOR unit's `a`/`b` inputs in ascending order, holding each for a programmable dwell time. It compares the unit's `c` output against the expected `a ^ b` and reports pass/fail, the error count and the first failing vector. It sits between the system test controller and one XOR datapath instance.

## Interface
- `WIDTH`, default 1: XOR operand width in bits; legal range 1..4.
- `DWELL`, default 10: clock cycles each vector is held; legal range 1..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a test run; honoured only in IDLE.
- `dut_a`  out  WIDTH  operand a to the XOR datapath (registered).
- `dut_b`  out  WIDTH  operand b to the XOR datapath (registered).
- `dut_c`  in  WIDTH  XOR datapath result.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  result of the last completed run; held until the next accepted start.
- `err_cnt`  out  2*WIDTH+1  mismatches in the current or last run.
- `fail_vec`  out  2*WIDTH  first failing `{dut_a,dut_b}`; 0 if there are no failures.

## Operation
- Vector counter `vec` is 2*WIDTH bits wide; `dut_a = vec[2W-1:W]`, `dut_b = vec[W-1:0]`. For WIDTH=1 the order is (a,b) = 00, 01, 10, 11.
- Dwell counter `dw` is 8 bits.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when `start`=1:
  - `vec`=0, `dw`=0
  - `err_cnt`=0, `fail_vec`=0, `pass`=0
- RUN, when `dw` < DWELL-1: `dw`++.
- RUN, when `dw` = DWELL-1 (sample cycle):
  - Compare `dut_c` against `dut_a ^ dut_b`.
  - On mismatch: `err_cnt`++. If this is the first mismatch, latch `fail_vec = vec`.
  - Then, if `vec` = all-ones: go to DONE. Otherwise `vec`++ and `dw`=0.
- DONE -> IDLE unconditionally after one cycle. In DONE: `done`=1 and `pass = (err_cnt==0)`.
- `start` is ignored in RUN and DONE; it is not queued.
- `dut_a`/`dut_b` return to 0 in IDLE and DONE.
- `err_cnt` never overflows: at most 2^(2W) errors, and the counter is 2W+1 bits wide.

## Timing
- Reset values: state=IDLE; `dut_a`=0, `dut_b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0.
- Reset takes effect immediately, including mid-run. No partial result is retained.
- Edge E samples `start`=1 in IDLE. From E+1 onward `busy`=1 and vector 0 is on `dut_a`/`dut_b`.
- Each vector is held exactly DWELL cycles. `dut_c` is sampled on its last cycle.
- The datapath must settle within DWELL cycles. With DWELL=1 the datapath is sampled in the same cycle the vector is applied, so it must be combinational.
- A full run is 2^(2W)·DWELL cycles with `busy`=1, followed by one cycle with `done`=1 and `busy`=0.
- `pass` and `err_cnt` are final in the DONE cycle and stable afterwards.
- Simultaneous mismatch and last vector: the error is counted, and DONE reflects it.

## Configuration
- `XOR_BIST_STOP_ON_FAIL_EN` defined: the first mismatch ends the run.
  - The FSM goes RUN -> DONE directly after the sample cycle.
  - Result: `err_cnt`=1, `fail_vec` = the failing vector, `pass`=0.
  - Run length: (fail_vec+1)·DWELL cycles.
- Not defined: all vectors are always applied, and `err_cnt` holds the total mismatch count.

## Test plan
- Good DUT, WIDTH=1, DWELL=10, start pulse:
  - `busy` high for 40 cycles.
  - `dut_a`/`dut_b` show 00, 01, 10, 11 for 10 cycles each.
  - `done` pulses once; then `pass`=1, `err_cnt`=0, `fail_vec`=0.
- `dut_c` stuck at 0, macro undefined: `err_cnt`=2, `fail_vec`=2'b01, `pass`=0.
- `dut_c` stuck at 0, macro defined: run ends after 20 busy cycles; `err_cnt`=1, `fail_vec`=2'b01, `pass`=0.
- Start re-pulsed at cycle 5 of a run: ignored, total still 40 busy cycles. Then `rst_n` low at cycle 15 of a new run: all outputs 0 asynchronously, FSM in IDLE.
- WIDTH=2, DWELL=1, DUT computes XNOR:
  - 16 busy cycles.
  - `err_cnt`=16, `fail_vec`=4'b0000, `pass`=0.
- Back-to-back runs: start asserted in the cycle after `done`. Run 2 clears `pass`/`err_cnt` at acceptance and completes normally.
